// File: rtl/mini_core_mem_stage_if.sv
// Data-memory request/response bus between the mini core memory stage and the memory.
interface mini_core_mem_stage_if;
    logic        DMemReqValid;
    logic        DMemReqReady;
    logic [31:0] DMemReqAddr;
    logic        DMemReqWrEn;
    logic [3:0]  DMemReqByteEn;
    logic [31:0] DMemReqWrData;
    logic        DMemRspValid;
    logic [31:0] DMemRspData;

    modport master (
        output DMemReqValid, DMemReqAddr, DMemReqWrEn, DMemReqByteEn, DMemReqWrData,
        input  DMemReqReady, DMemRspValid, DMemRspData
    );

    modport slave (
        input  DMemReqValid, DMemReqAddr, DMemReqWrEn, DMemReqByteEn, DMemReqWrData,
        output DMemReqReady, DMemRspValid, DMemRspData
    );
endinterface

// File: rtl/mini_core_mem_stage.sv
// Mini core Q103H memory stage: load/store sequencing, lane steering and Q104H writeback flops.
// Optional misaligned-access trap is enabled by defining MINI_CORE_MISALIGN_CHK_EN.
module mini_core_mem_stage #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        Clock,
    input  logic        Rst,
    input  logic        DMemRdEnQ103H,
    input  logic        DMemWrEnQ103H,
    input  logic [1:0]  DMemSizeQ103H,
    input  logic        SignExtQ103H,
    input  logic [1:0]  WbSelQ103H,
    input  logic        RegWrEnQ103H,
    input  logic [4:0]  RegDstQ103H,
    input  logic [31:0] AluOutQ103H,
    input  logic [31:0] PcPlus4Q103H,
    input  logic [31:0] DMemWrDataQ103H,
    mini_core_mem_stage_if.master dmem,
    output logic        ReadyQ103H,
    output logic [31:0] RegWrDataQ104H,
    output logic        RegWrEnQ104H,
    output logic [4:0]  RegDstQ104H,
    output logic        MisalignQ104H,
    output logic        TimeoutErr
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT_RSP} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_timeout_err;
    logic               r_misalign;
    logic [31:0]        r_wr_data;
    logic               r_wr_en;
    logic [4:0]         r_dst;

    logic               w_mem_op;
    logic               w_is_store;
    logic               w_is_word;
    logic               w_is_half;
    logic               w_misalign;
    logic               w_misalign_hit;
    logic               w_req_valid;
    logic               w_ready;
    logic               w_timeout;
    logic               w_load_valid;
    logic [1:0]         w_lane;
    logic [3:0]         w_byte_en;
    logic [31:0]        w_wr_data;
    logic [31:0]        w_rsp_shifted;
    logic [31:0]        w_load_ext;
    logic [31:0]        w_load_data;
    logic [31:0]        w_wb_data;

    assign w_mem_op   = DMemWrEnQ103H | DMemRdEnQ103H;
    assign w_is_store = DMemWrEnQ103H;
    assign w_is_word  = DMemSizeQ103H[1];
    assign w_is_half  = (DMemSizeQ103H == 2'b01);

`ifdef MINI_CORE_MISALIGN_CHK_EN
    assign w_misalign = w_mem_op & ((w_is_half & AluOutQ103H[0]) |
                                    (w_is_word & (AluOutQ103H[1:0] != 2'b00)));
`else
    assign w_misalign = 1'b0;
`endif

    // Lane steering: word ignores addr[1:0], half ignores addr[0].
    always_comb begin
        w_lane    = 2'b00;
        w_byte_en = 4'b1111;
        w_wr_data = DMemWrDataQ103H;
        if (!w_is_word && w_is_half) begin
            w_lane    = {AluOutQ103H[1], 1'b0};
            w_byte_en = 4'b0011 << w_lane;
            w_wr_data = {2{DMemWrDataQ103H[15:0]}};
        end else if (!w_is_word) begin
            w_lane    = AluOutQ103H[1:0];
            w_byte_en = 4'b0001 << w_lane;
            w_wr_data = {4{DMemWrDataQ103H[7:0]}};
        end
    end

    always_comb begin
        w_rsp_shifted = dmem.DMemRspData >> {w_lane, 3'b000};
        w_load_ext    = w_rsp_shifted;
        if (!w_is_word && w_is_half)
            w_load_ext = {{16{SignExtQ103H & w_rsp_shifted[15]}}, w_rsp_shifted[15:0]};
        else if (!w_is_word)
            w_load_ext = {{24{SignExtQ103H & w_rsp_shifted[7]}}, w_rsp_shifted[7:0]};
        w_load_data = w_load_valid ? w_load_ext : 32'h0;
    end

    always_comb begin
        case (WbSelQ103H)
            2'b01:   w_wb_data = w_load_data;
            2'b10:   w_wb_data = PcPlus4Q103H;
            default: w_wb_data = AluOutQ103H;
        endcase
    end

    // Next-state and handshake decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_req_valid    = 1'b0;
        w_ready        = 1'b0;
        w_timeout      = 1'b0;
        w_load_valid   = 1'b0;
        w_misalign_hit = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_mem_op) begin
                    w_ready = 1'b1;
                end else if (w_misalign) begin
                    w_ready        = 1'b1;
                    w_misalign_hit = 1'b1;
                end else begin
                    w_req_valid = 1'b1;
                    if (!dmem.DMemReqReady)
                        w_state_nxt = ST_REQ;
                    else if (w_is_store)
                        w_ready = 1'b1;
                    else
                        w_state_nxt = ST_WAIT_RSP;
                end
            end
            ST_REQ: begin
                w_req_valid = 1'b1;
                if (dmem.DMemReqReady) begin
                    if (w_is_store) begin
                        w_ready     = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_WAIT_RSP;
                    end
                end
            end
            ST_WAIT_RSP: begin
                if (dmem.DMemRspValid) begin
                    w_ready      = 1'b1;
                    w_load_valid = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    w_ready     = 1'b1;
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
            r_misalign    <= 1'b0;
            r_wr_data     <= 32'h0;
            r_wr_en       <= 1'b0;
            r_dst         <= 5'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= (r_state == ST_WAIT_RSP) ? r_cnt + CNT_W'(1) : '0;
            r_timeout_err <= r_timeout_err | w_timeout;
            r_misalign    <= w_misalign_hit;
            if (w_ready) begin
                r_wr_data <= w_wb_data;
                r_wr_en   <= RegWrEnQ103H & ~w_misalign_hit;
                r_dst     <= RegDstQ103H;
            end else begin
                r_wr_en   <= 1'b0;
            end
        end
    end

    // Request valid drops immediately under reset even if a memory op is presented.
    assign dmem.DMemReqValid  = w_req_valid & ~Rst;
    assign dmem.DMemReqAddr   = {AluOutQ103H[31:2], 2'b00};
    assign dmem.DMemReqWrEn   = w_is_store;
    assign dmem.DMemReqByteEn = w_byte_en;
    assign dmem.DMemReqWrData = w_wr_data;

    assign ReadyQ103H     = w_ready;
    assign RegWrDataQ104H = r_wr_data;
    assign RegWrEnQ104H   = r_wr_en;
    assign RegDstQ104H    = r_dst;
    assign MisalignQ104H  = r_misalign;
    assign TimeoutErr     = r_timeout_err;

endmodule

// File: tb/tb_mini_core_mem_stage.sv
// Directed bench for mini_core_mem_stage (TIMEOUT_CYC=4); covers MINI_CORE_MISALIGN_CHK_EN either way.
module tb_mini_core_mem_stage;
    logic        Clock;
    logic        Rst;
    logic        DMemRdEnQ103H, DMemWrEnQ103H, SignExtQ103H, RegWrEnQ103H;
    logic [1:0]  DMemSizeQ103H, WbSelQ103H;
    logic [4:0]  RegDstQ103H;
    logic [31:0] AluOutQ103H, PcPlus4Q103H, DMemWrDataQ103H;
    logic        ReadyQ103H, RegWrEnQ104H, MisalignQ104H, TimeoutErr;
    logic [31:0] RegWrDataQ104H;
    logic [4:0]  RegDstQ104H;

    int total = 0;
    int bad   = 0;

    mini_core_mem_stage_if dmem ();

    mini_core_mem_stage #(.TIMEOUT_CYC(4)) dut (
        .Clock(Clock), .Rst(Rst),
        .DMemRdEnQ103H(DMemRdEnQ103H), .DMemWrEnQ103H(DMemWrEnQ103H),
        .DMemSizeQ103H(DMemSizeQ103H), .SignExtQ103H(SignExtQ103H),
        .WbSelQ103H(WbSelQ103H), .RegWrEnQ103H(RegWrEnQ103H), .RegDstQ103H(RegDstQ103H),
        .AluOutQ103H(AluOutQ103H), .PcPlus4Q103H(PcPlus4Q103H), .DMemWrDataQ103H(DMemWrDataQ103H),
        .dmem(dmem.master),
        .ReadyQ103H(ReadyQ103H), .RegWrDataQ104H(RegWrDataQ104H), .RegWrEnQ104H(RegWrEnQ104H),
        .RegDstQ104H(RegDstQ104H), .MisalignQ104H(MisalignQ104H), .TimeoutErr(TimeoutErr)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_inputs();
        DMemRdEnQ103H = 0; DMemWrEnQ103H = 0; DMemSizeQ103H = 2'b10; SignExtQ103H = 0;
        WbSelQ103H = 2'b00; RegWrEnQ103H = 0; RegDstQ103H = 0;
        AluOutQ103H = 0; PcPlus4Q103H = 0; DMemWrDataQ103H = 0;
        dmem.DMemReqReady = 0; dmem.DMemRspValid = 0; dmem.DMemRspData = 0;
    endtask

    initial begin
        idle_inputs();
        Rst = 1'b1;
        DMemWrEnQ103H = 1'b1;
        #12;
        chk("rst_req_valid", 32'(dmem.DMemReqValid), 32'd0);
        chk("rst_wdata", RegWrDataQ104H, 32'h0);
        chk("rst_wen", 32'(RegWrEnQ104H), 32'd0);
        chk("rst_terr", 32'(TimeoutErr), 32'd0);
        chk("rst_misalign", 32'(MisalignQ104H), 32'd0);
        DMemWrEnQ103H = 1'b0;
        tick();
        Rst = 1'b0;

        // ALU op, writeback of AluOut
        AluOutQ103H = 32'h1234; RegDstQ103H = 5; RegWrEnQ103H = 1; WbSelQ103H = 2'b00;
        #1;
        chk("alu_ready", 32'(ReadyQ103H), 32'd1);
        chk("alu_no_req", 32'(dmem.DMemReqValid), 32'd0);
        tick();
        chk("alu_wdata", RegWrDataQ104H, 32'h1234);
        chk("alu_dst", 32'(RegDstQ104H), 32'd5);
        chk("alu_wen", 32'(RegWrEnQ104H), 32'd1);

        // Link writeback, then WbSel=11 falls back to AluOut
        WbSelQ103H = 2'b10; PcPlus4Q103H = 32'h2000; RegDstQ103H = 7;
        tick();
        chk("link_wdata", RegWrDataQ104H, 32'h2000);
        WbSelQ103H = 2'b11; AluOutQ103H = 32'h0BAD;
        tick();
        chk("wbsel11_wdata", RegWrDataQ104H, 32'h0BAD);

        // Store byte 0x103 with ready held off three cycles
        RegWrEnQ103H = 0; WbSelQ103H = 2'b00;
        DMemWrEnQ103H = 1; DMemSizeQ103H = 2'b00; AluOutQ103H = 32'h103; DMemWrDataQ103H = 32'h55AB;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("st_valid_wait", 32'(dmem.DMemReqValid), 32'd1);
            chk("st_ready_wait", 32'(ReadyQ103H), 32'd0);
            tick();
        end
        chk("st_bubble", 32'(RegWrEnQ104H), 32'd0);
        chk("st_byteen", 32'(dmem.DMemReqByteEn), 32'b1000);
        chk("st_wrdata", dmem.DMemReqWrData, 32'hABABABAB);
        chk("st_addr", dmem.DMemReqAddr, 32'h100);
        chk("st_wren", 32'(dmem.DMemReqWrEn), 32'd1);
        dmem.DMemReqReady = 1;
        #1;
        chk("st_valid_acc", 32'(dmem.DMemReqValid), 32'd1);
        chk("st_ready_acc", 32'(ReadyQ103H), 32'd1);
        tick();
        DMemWrEnQ103H = 0; dmem.DMemReqReady = 0;
        #1;
        chk("st_done_valid", 32'(dmem.DMemReqValid), 32'd0);
        chk("st_done_ready", 32'(ReadyQ103H), 32'd1);
        tick();

        // Signed half load 0x102, response two cycles after accept
        DMemRdEnQ103H = 1; DMemSizeQ103H = 2'b01; SignExtQ103H = 1; WbSelQ103H = 2'b01;
        RegWrEnQ103H = 1; RegDstQ103H = 9; AluOutQ103H = 32'h102; dmem.DMemReqReady = 1;
        dmem.DMemRspValid = 1; dmem.DMemRspData = 32'hDEAD_BEEF;
        #1;
        chk("ldh_valid", 32'(dmem.DMemReqValid), 32'd1);
        chk("ldh_byteen", 32'(dmem.DMemReqByteEn), 32'b1100);
        chk("ldh_wren_req", 32'(dmem.DMemReqWrEn), 32'd0);
        chk("ldh_acc_rsp_ignored", 32'(ReadyQ103H), 32'd0);
        tick();
        dmem.DMemReqReady = 0; dmem.DMemRspValid = 0;
        #1;
        chk("ldh_wait_valid", 32'(dmem.DMemReqValid), 32'd0);
        chk("ldh_wait_ready", 32'(ReadyQ103H), 32'd0);
        chk("ldh_stall_wen", 32'(RegWrEnQ104H), 32'd0);
        tick();
        dmem.DMemRspValid = 1; dmem.DMemRspData = 32'h8001_0000;
        #1;
        chk("ldh_rsp_ready", 32'(ReadyQ103H), 32'd1);
        tick();
        dmem.DMemRspValid = 0; DMemRdEnQ103H = 0; RegWrEnQ103H = 0;
        chk("ldh_wdata", RegWrDataQ104H, 32'hFFFF_8001);
        chk("ldh_wen", 32'(RegWrEnQ104H), 32'd1);
        chk("ldh_dst", 32'(RegDstQ104H), 32'd9);

        // Unsigned byte load 0x101, minimum latency
        DMemRdEnQ103H = 1; DMemSizeQ103H = 2'b00; SignExtQ103H = 0; RegWrEnQ103H = 1;
        RegDstQ103H = 4; AluOutQ103H = 32'h101; dmem.DMemReqReady = 1;
        tick();
        dmem.DMemReqReady = 0; dmem.DMemRspValid = 1; dmem.DMemRspData = 32'h0000_C300;
        tick();
        dmem.DMemRspValid = 0; DMemRdEnQ103H = 0; RegWrEnQ103H = 0;
        chk("ldb_wdata", RegWrDataQ104H, 32'h0000_00C3);

        // Word load with no response: times out after four WAIT_RSP cycles
        DMemRdEnQ103H = 1; DMemSizeQ103H = 2'b10; RegWrEnQ103H = 1; RegDstQ103H = 3;
        AluOutQ103H = 32'h200; dmem.DMemReqReady = 1;
        tick();
        dmem.DMemReqReady = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("to_wait_ready", 32'(ReadyQ103H), 32'd0);
            tick();
        end
        chk("to_err_before", 32'(TimeoutErr), 32'd0);
        chk("to_ready", 32'(ReadyQ103H), 32'd1);
        tick();
        DMemRdEnQ103H = 0; RegWrEnQ103H = 0;
        chk("to_wdata", RegWrDataQ104H, 32'h0);
        chk("to_wen", 32'(RegWrEnQ104H), 32'd1);
        chk("to_err", 32'(TimeoutErr), 32'd1);
        dmem.DMemRspValid = 1; dmem.DMemRspData = 32'h1111_1111;
        #1;
        chk("to_late_ready", 32'(ReadyQ103H), 32'd1);
        tick();
        dmem.DMemRspValid = 0;
        tick();
        chk("to_err_sticky", 32'(TimeoutErr), 32'd1);

        // Reset pulsed while waiting for a load response
        WbSelQ103H = 2'b00; AluOutQ103H = 32'h55; RegDstQ103H = 6; RegWrEnQ103H = 1;
        tick();
        WbSelQ103H = 2'b01; DMemRdEnQ103H = 1; AluOutQ103H = 32'h300; dmem.DMemReqReady = 1;
        tick();
        dmem.DMemReqReady = 0;
        Rst = 1;
        #1;
        chk("rw_valid", 32'(dmem.DMemReqValid), 32'd0);
        chk("rw_wdata", RegWrDataQ104H, 32'h0);
        chk("rw_wen", 32'(RegWrEnQ104H), 32'd0);
        chk("rw_dst", 32'(RegDstQ104H), 32'd0);
        chk("rw_terr", 32'(TimeoutErr), 32'd0);
        tick();
        Rst = 0; DMemRdEnQ103H = 0; RegWrEnQ103H = 0;
        dmem.DMemRspValid = 1; dmem.DMemRspData = 32'h0000_0077;
        tick();
        dmem.DMemRspValid = 0;
        chk("rw_late_wen", 32'(RegWrEnQ104H), 32'd0);
        chk("rw_late_wdata", RegWrDataQ104H, 32'h0);

        // Misaligned word load at 0x101
        DMemRdEnQ103H = 1; DMemSizeQ103H = 2'b10; RegWrEnQ103H = 1; RegDstQ103H = 8;
        AluOutQ103H = 32'h101;
`ifdef MINI_CORE_MISALIGN_CHK_EN
        #1;
        chk("mis_no_req", 32'(dmem.DMemReqValid), 32'd0);
        chk("mis_ready", 32'(ReadyQ103H), 32'd1);
        tick();
        DMemRdEnQ103H = 0; RegWrEnQ103H = 0;
        chk("mis_flag", 32'(MisalignQ104H), 32'd1);
        chk("mis_wen", 32'(RegWrEnQ104H), 32'd0);
        tick();
        chk("mis_flag_once", 32'(MisalignQ104H), 32'd0);
`else
        dmem.DMemReqReady = 1;
        #1;
        chk("mis_req_valid", 32'(dmem.DMemReqValid), 32'd1);
        chk("mis_byteen", 32'(dmem.DMemReqByteEn), 32'b1111);
        chk("mis_addr", dmem.DMemReqAddr, 32'h100);
        tick();
        dmem.DMemReqReady = 0; dmem.DMemRspValid = 1; dmem.DMemRspData = 32'h1122_3344;
        tick();
        dmem.DMemRspValid = 0; DMemRdEnQ103H = 0; RegWrEnQ103H = 0;
        chk("mis_flag_off", 32'(MisalignQ104H), 32'd0);
        chk("mis_wdata", RegWrDataQ104H, 32'h1122_3344);
        chk("mis_wen", 32'(RegWrEnQ104H), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
